// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline hazard/stall controller:
//   - stage index constants for the 6-bit stall vector (PC..WB)
//   - per-cause stall masks
//   - tracker FSM state enums
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Bit positions inside the stall vector.
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;

  // A cause holds every stage up to and including the one that owns the hazard;
  // the first clear bit above it turns into a bubble.
  localparam logic [5:0] STALL_MEM_MASK = 6'b011111;
  localparam logic [5:0] STALL_DIV_MASK = 6'b001111;
  localparam logic [5:0] STALL_LU_MASK  = 6'b000111;

  typedef enum logic {
    M_IDLE = 1'b0,
    M_WAIT = 1'b1
  } mem_state_e;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_BUSY = 1'b1
  } div_state_e;

endpackage

// File: rtl/pipe_stall_ctrl_timer.sv
// -----------------------------------------------------------------------------
// stall_timer
// Loadable up/down counter with a terminal-count flag, shared by the MEM
// wait tracker (counts up to the timeout) and the DIV tracker (counts down).
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (count clears to 0)
//   load        load load_val this cycle (has priority over en)
//   load_val    value to load
//   en          step the counter this cycle
//   up          step direction: 1 = increment, 0 = decrement
//   term_val    value at which term is raised
//   term        count currently equals term_val
// -----------------------------------------------------------------------------
module stall_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term_val,
  output logic         term
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: load wins over stepping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      if (up) begin
        cnt_d = cnt_q + W'(1);
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == term_val);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_stall_ctrl
// Central hazard/stall controller for the 5-stage pipeline. Combines MEM
// wait-state, fixed-latency divide and load-use hazards into one stall vector
// and generates the taken-branch flush.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   id_load_use       ID consumes rd of a load currently in EX
//   ex_div_start      EX holds a div/rem that has not yet started
//   ex_branch_taken   branch/jump resolved taken in EX
//   mem_req           MEM stage issues a data-memory access
//   dmem_ready        data memory completes the access this cycle
//   stall[5:0]        per-stage hold (0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB)
//   flush_ifid        clear IF/ID this cycle
//   flush_idex        clear ID/EX this cycle
//   div_done          one-cycle pulse, divide result valid in EX
//   mem_err           one-cycle pulse, memory access timed out
// Optional feature (macro PIPE_STALL_PERF_CNT_EN):
//   perf_mem_stall, perf_div_stall, perf_lu_stall  32-bit wrapping counters
//   of cycles in which each cause mask is active; cleared only by rst_n.
// -----------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = 8,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_load_use,
  input  logic        ex_div_start,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        dmem_ready,
  output logic [5:0]  stall,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        div_done,
  output logic        mem_err
`ifdef PIPE_STALL_PERF_CNT_EN
  ,
  output logic [31:0] perf_mem_stall,
  output logic [31:0] perf_div_stall,
  output logic [31:0] perf_lu_stall
`endif
);

  localparam logic [9:0] WCNT_ONE  = 10'd1;
  localparam logic [9:0] WCNT_TERM = 10'(MEM_TIMEOUT - 1);
  localparam logic [7:0] DCNT_LOAD = 8'(DIV_LATENCY - 1);
  localparam logic [7:0] DCNT_TERM = 8'd1;

  // ---------------------------------------------------------------------------
  // MEM wait tracker
  // ---------------------------------------------------------------------------
  mem_state_e mem_state_q, mem_state_d;
  logic       mem_err_q, mem_err_d;
  logic       mem_mask;
  logic       wcnt_load, wcnt_en, wcnt_term;

  stall_timer #(.W(10)) u_wcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (wcnt_load),
    .load_val (WCNT_ONE),
    .en       (wcnt_en),
    .up       (1'b1),
    .term_val (WCNT_TERM),
    .term     (wcnt_term)
  );

  // MEM tracker next state. On the mem_err cycle the aborted access is
  // leaving MEM, so a still-high mem_req must not start a fresh wait.
  always_comb begin
    mem_state_d = mem_state_q;
    mem_err_d   = 1'b0;
    mem_mask    = 1'b0;
    wcnt_load   = 1'b0;
    wcnt_en     = 1'b0;
    case (mem_state_q)
      M_IDLE: begin
        if (mem_req && !dmem_ready && !mem_err_q) begin
          mem_mask    = 1'b1;
          wcnt_load   = 1'b1;
          mem_state_d = M_WAIT;
        end else begin
          mem_state_d = M_IDLE;
        end
      end
      M_WAIT: begin
        if (dmem_ready) begin
          mem_state_d = M_IDLE;
        end else if (wcnt_term) begin
          // Last stalled cycle: the abort is reported on the next cycle.
          mem_mask    = 1'b1;
          mem_err_d   = 1'b1;
          mem_state_d = M_IDLE;
        end else begin
          mem_mask    = 1'b1;
          wcnt_en     = 1'b1;
        end
      end
      default: begin
        mem_state_d = M_IDLE;
      end
    endcase
  end

  // MEM tracker state and registered error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_state_q <= M_IDLE;
      mem_err_q   <= 1'b0;
    end else begin
      mem_state_q <= mem_state_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // DIV tracker
  // ---------------------------------------------------------------------------
  div_state_e div_state_q, div_state_d;
  logic       div_done_q, div_done_d;
  logic       div_mask;
  logic       dcnt_load, dcnt_en, dcnt_term;

  stall_timer #(.W(8)) u_dcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (dcnt_load),
    .load_val (DCNT_LOAD),
    .en       (dcnt_en),
    .up       (1'b0),
    .term_val (DCNT_TERM),
    .term     (dcnt_term)
  );

  // DIV tracker next state. A start is only taken when nothing else holds EX
  // (MEM is the only other cause owning stall[3]) and not on the div_done
  // cycle, where ex_div_start still reflects the finished instruction.
  always_comb begin
    div_state_d = div_state_q;
    div_done_d  = 1'b0;
    div_mask    = 1'b0;
    dcnt_load   = 1'b0;
    dcnt_en     = 1'b0;
    case (div_state_q)
      D_IDLE: begin
        if (ex_div_start && !mem_mask && !div_done_q) begin
          div_mask    = 1'b1;
          dcnt_load   = 1'b1;
          div_state_d = D_BUSY;
        end else begin
          div_state_d = D_IDLE;
        end
      end
      D_BUSY: begin
        // Counts regardless of MEM stalls: the divider runs free once started.
        div_mask = 1'b1;
        dcnt_en  = 1'b1;
        if (dcnt_term) begin
          div_done_d  = 1'b1;
          div_state_d = D_IDLE;
        end else begin
          div_state_d = D_BUSY;
        end
      end
      default: begin
        div_state_d = D_IDLE;
      end
    endcase
  end

  // DIV tracker state and registered done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_state_q <= D_IDLE;
      div_done_q  <= 1'b0;
    end else begin
      div_state_q <= div_state_d;
      div_done_q  <= div_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall / flush combination
  // ---------------------------------------------------------------------------
  logic [5:0] hold_mask;
  logic       flush;
  logic       lu_mask;

  // Merge causes. Flush discards the younger instructions, so it suppresses
  // the load-use bubble; flush itself is only possible when EX is not held.
  always_comb begin
    hold_mask = 6'b000000;
    if (mem_mask) begin
      hold_mask = hold_mask | STALL_MEM_MASK;
    end else begin
      hold_mask = hold_mask;
    end
    if (div_mask) begin
      hold_mask = hold_mask | STALL_DIV_MASK;
    end else begin
      hold_mask = hold_mask;
    end
    flush   = ex_branch_taken && !hold_mask[STG_EX];
    lu_mask = id_load_use && !mem_mask && !div_mask && !flush;
    if (lu_mask) begin
      stall = hold_mask | STALL_LU_MASK;
    end else begin
      stall = hold_mask;
    end
  end

  assign flush_ifid = flush;
  assign flush_idex = flush;
  assign div_done   = div_done_q;
  assign mem_err    = mem_err_q;

`ifdef PIPE_STALL_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
  logic [31:0] perf_mem_q, perf_mem_d;
  logic [31:0] perf_div_q, perf_div_d;
  logic [31:0] perf_lu_q,  perf_lu_d;

  // Per-cause cycle counts, wrapping naturally at 2^32.
  always_comb begin
    perf_mem_d = perf_mem_q + {31'd0, mem_mask};
    perf_div_d = perf_div_q + {31'd0, div_mask};
    perf_lu_d  = perf_lu_q  + {31'd0, lu_mask};
  end

  // Counter registers, cleared only by the hardware reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mem_q <= 32'd0;
      perf_div_q <= 32'd0;
      perf_lu_q  <= 32'd0;
    end else begin
      perf_mem_q <= perf_mem_d;
      perf_div_q <= perf_div_d;
      perf_lu_q  <= perf_lu_d;
    end
  end

  assign perf_mem_stall = perf_mem_q;
  assign perf_div_stall = perf_div_q;
  assign perf_lu_stall  = perf_lu_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Self-checking bench for pipe_stall_ctrl (DIV_LATENCY=8, MEM_TIMEOUT=64).
// Each scenario task drives one cycle at a time, pushes the expected
// {stall, flush_ifid, flush_idex, div_done, mem_err} into a scoreboard queue,
// then pops and compares it against the DUT at the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam logic [5:0] M_MASK = 6'b011111;
  localparam logic [5:0] D_MASK = 6'b001111;
  localparam logic [5:0] L_MASK = 6'b000111;
  localparam logic [5:0] NONE   = 6'b000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       id_load_use = 1'b0;
  logic       ex_div_start = 1'b0;
  logic       ex_branch_taken = 1'b0;
  logic       mem_req = 1'b0;
  logic       dmem_ready = 1'b0;
  logic [5:0] stall;
  logic       flush_ifid, flush_idex, div_done, mem_err;
`ifdef PIPE_STALL_PERF_CNT_EN
  logic [31:0] perf_mem_stall, perf_div_stall, perf_lu_stall;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] sb_q[$];
  logic [9:0] obs;
  logic [9:0] exp_v;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.DIV_LATENCY(8), .MEM_TIMEOUT(64)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_load_use     (id_load_use),
    .ex_div_start    (ex_div_start),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .stall           (stall),
    .flush_ifid      (flush_ifid),
    .flush_idex      (flush_idex),
    .div_done        (div_done),
    .mem_err         (mem_err)
`ifdef PIPE_STALL_PERF_CNT_EN
    ,
    .perf_mem_stall  (perf_mem_stall),
    .perf_div_stall  (perf_div_stall),
    .perf_lu_stall   (perf_lu_stall)
`endif
  );

  assign obs = {stall, flush_ifid, flush_idex, div_done, mem_err};

  function automatic logic [9:0] ev(logic [5:0] s, logic f, logic d, logic m);
    return {s, f, f, d, m};
  endfunction

  task automatic apply(logic lu, logic ds, logic bt, logic mr, logic rdy);
    id_load_use     = lu;
    ex_div_start    = ds;
    ex_branch_taken = bt;
    mem_req         = mr;
    dmem_ready      = rdy;
  endtask

  task automatic test_reset();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    sb_q.push_back(ev(NONE, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    exp_v = sb_q.pop_front();
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL reset: got %b expected %b", obs, exp_v);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Ready after three wait cycles: three stalled cycles, release on ready.
  task automatic test_mem_wait();
    for (int c = 0; c < 5; c++) begin
      apply(1'b0, 1'b0, 1'b0, c < 4, c == 3);
      sb_q.push_back(ev((c < 3) ? M_MASK : NONE, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mem_wait[%0d]: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Never ready: 64 stalled cycles, then a single mem_err pulse with stall 0.
  task automatic test_mem_timeout();
    for (int c = 0; c < 67; c++) begin
      apply(1'b0, 1'b0, 1'b0, c < 65, 1'b0);
      sb_q.push_back(ev((c < 64) ? M_MASK : NONE, 1'b0, 1'b0, c == 64));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mem_timeout[%0d]: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Start held high through the divide and the done cycle: only one divide.
  task automatic test_div();
    for (int c = 0; c < 11; c++) begin
      apply(1'b0, c < 9, 1'b0, 1'b0, 1'b0);
      sb_q.push_back(ev((c < 8) ? D_MASK : NONE, 1'b0, c == 8, 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL div[%0d]: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Load-use bubble, then load-use with branch: flush wins.
  task automatic test_load_use();
    for (int c = 0; c < 3; c++) begin
      apply(c < 2, 1'b0, c == 1, 1'b0, 1'b0);
      sb_q.push_back(ev((c == 0) ? L_MASK : NONE, c == 1, 1'b0, 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Branch held in EX by a MEM wait flushes on the ready cycle.
  task automatic test_branch_mem();
    for (int c = 0; c < 4; c++) begin
      apply(1'b0, 1'b0, c < 3, c < 3, c == 2);
      sb_q.push_back(ev((c < 2) ? M_MASK : NONE, c == 2, 1'b0, 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL branch_mem[%0d]: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Divide request during a MEM wait starts on the ready cycle.
  task automatic test_mem_then_div();
    for (int c = 0; c < 11; c++) begin
      apply(1'b0, c < 2, 1'b0, c < 2, c == 1);
      if (c == 0) begin
        sb_q.push_back(ev(M_MASK, 1'b0, 1'b0, 1'b0));
      end else begin
        sb_q.push_back(ev((c < 9) ? D_MASK : NONE, 1'b0, c == 9, 1'b0));
      end
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL mem_then_div[%0d]: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  // Reset mid-divide (counter at 4): outputs clear, no done pulse afterwards.
  task automatic test_reset_mid_div();
    for (int c = 0; c < 16; c++) begin
      apply(1'b0, c == 0, 1'b0, 1'b0, 1'b0);
      if (c == 4) begin
        #2 rst_n = 1'b0;
      end else if (c == 7) begin
        rst_n = 1'b1;
      end else begin
        rst_n = rst_n;
      end
      sb_q.push_back(ev((c < 4) ? D_MASK : NONE, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      exp_v = sb_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL reset_mid_div[%0d]: got %b expected %b", c, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_mem_wait();
    test_mem_timeout();
    test_div();
    test_load_use();
    test_branch_mem();
    test_mem_then_div();
    test_reset_mid_div();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
